// File: rtl/sprite_anim_ctrl_if.sv
// Signal bundle between the frame/keyboard front end and the player sprite
// animation sequencer.
interface sprite_anim_ctrl_if;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [3:0] sprite_sel;
    logic [1:0] dir;
    logic       walk_frame;
    logic       attacking;
    logic       moving;

    modport master (
        output frame_tick,
        output keycode,
        input  sprite_sel,
        input  dir,
        input  walk_frame,
        input  attacking,
        input  moving
    );

    modport slave (
        input  frame_tick,
        input  keycode,
        output sprite_sel,
        output dir,
        output walk_frame,
        output attacking,
        output moving
    );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Player sprite animation sequencer: samples the keycode once per frame tick and
// tracks facing direction, walk-cycle phase and a timed, non-interruptible attack.
module sprite_anim_ctrl #(
    parameter int FRAME_DIV     = 8,
    parameter int ATTACK_FRAMES = 12
) (
    input  logic               vga_clk,
    input  logic               Reset,
    sprite_anim_ctrl_if.slave  bus
);

    localparam int DIV_W = $clog2(FRAME_DIV + 1);
    localparam int ATK_W = $clog2(ATTACK_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [ATK_W-1:0] ATK_LOAD = ATK_W'(ATTACK_FRAMES - 1);

    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        ATTACK = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         dir;
    logic               walk_frame;
    logic [DIV_W-1:0]   div_cnt;
    logic [ATK_W-1:0]   atk_cnt;
    logic               atk_prev;
    logic [3:0]         sprite_sel;
    logic               attacking;
    logic               moving;

    logic               dir_key;
    logic [1:0]         key_dir;
    logic               atk_key;
    logic               atk_edge;

    state_t             state_n;
    logic [1:0]         dir_n;
    logic               walk_n;
    logic [DIV_W-1:0]   div_n;
    logic [ATK_W-1:0]   atk_n;

    always_comb begin
        dir_key = 1'b0;
        key_dir = 2'd0;
        atk_key = 1'b0;
        case (bus.keycode)
            KEY_DOWN:  begin dir_key = 1'b1; key_dir = 2'd0; end
            KEY_UP:    begin dir_key = 1'b1; key_dir = 2'd1; end
            KEY_LEFT:  begin dir_key = 1'b1; key_dir = 2'd2; end
            KEY_RIGHT: begin dir_key = 1'b1; key_dir = 2'd3; end
            KEY_SPACE: atk_key = 1'b1;
            default:   ;
        endcase
    end

    // Only the first tick of a held space bar starts an attack.
    assign atk_edge = atk_key & ~atk_prev;

    always_comb begin
        state_n = state;
        dir_n   = dir;
        walk_n  = walk_frame;
        div_n   = div_cnt;
        atk_n   = atk_cnt;
        case (state)
            IDLE: begin
                if (atk_edge) begin
                    state_n = ATTACK;
                    atk_n   = ATK_LOAD;
                end else if (dir_key) begin
                    state_n = WALK;
                    dir_n   = key_dir;
                    div_n   = '0;
                    walk_n  = 1'b0;
                end
            end
            WALK: begin
                if (atk_edge) begin
                    state_n = ATTACK;
                    atk_n   = ATK_LOAD;
                end else if (dir_key && (key_dir == dir)) begin
                    if (div_cnt == DIV_LAST) begin
                        div_n  = '0;
                        walk_n = ~walk_frame;
                    end else begin
                        div_n  = div_cnt + DIV_W'(1);
                    end
                end else if (dir_key) begin
                    dir_n = key_dir;
                    div_n = '0;
                end else begin
                    state_n = IDLE;
                    walk_n  = 1'b0;
                    div_n   = '0;
                end
            end
            ATTACK: begin
                if (atk_cnt == '0) begin
                    state_n = IDLE;
                    walk_n  = 1'b0;
                end else begin
                    atk_n = atk_cnt - ATK_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                walk_n  = 1'b0;
                div_n   = '0;
                atk_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they change exactly one
    // cycle after the tick that caused them and hold steady for the whole frame.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state      <= IDLE;
            dir        <= 2'd0;
            walk_frame <= 1'b0;
            div_cnt    <= '0;
            atk_cnt    <= '0;
            atk_prev   <= 1'b0;
            sprite_sel <= 4'd0;
            attacking  <= 1'b0;
            moving     <= 1'b0;
        end else if (bus.frame_tick) begin
            state      <= state_n;
            dir        <= dir_n;
            walk_frame <= walk_n;
            div_cnt    <= div_n;
            atk_cnt    <= atk_n;
            atk_prev   <= atk_key;
            sprite_sel <= (state_n == ATTACK) ? {2'b10, dir_n} : {1'b0, dir_n, walk_n};
            attacking  <= (state_n == ATTACK);
            moving     <= (state_n == WALK);
        end
    end

    assign bus.sprite_sel = sprite_sel;
    assign bus.dir        = dir;
    assign bus.walk_frame = walk_frame;
    assign bus.attacking  = attacking;
    assign bus.moving     = moving;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: directed walk/attack/reset scenarios plus random
// keys and ticks, checked every cycle against a frame-level behavioural model.
module tb_sprite_anim_ctrl;

    localparam int FRAME_DIV     = 8;
    localparam int ATTACK_FRAMES = 12;

    localparam int M_IDLE   = 0;
    localparam int M_WALK   = 1;
    localparam int M_ATTACK = 2;

    logic vga_clk = 1'b0;
    logic Reset;

    sprite_anim_ctrl_if bus ();

    sprite_anim_ctrl #(
        .FRAME_DIV     (FRAME_DIV),
        .ATTACK_FRAMES (ATTACK_FRAMES)
    ) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic check_en     = 1'b0;

    // Model: mode, facing, walk phase, same-direction tick count, and how many
    // ticks of the current attack have elapsed.
    int         m_mode       = M_IDLE;
    logic [1:0] m_dir        = 2'd0;
    logic       m_walk       = 1'b0;
    int         m_steps      = 0;
    int         m_atk_seen   = 0;
    logic       m_space_prev = 1'b0;

    function automatic int exp_sprite();
        if (m_mode == M_ATTACK) return 8 + int'(m_dir);
        return int'(m_dir) * 2 + int'(m_walk);
    endfunction

    task automatic model_tick(input logic [7:0] k);
        logic       is_dir;
        logic       is_space;
        logic [1:0] kd;
        logic       edge_hit;
        is_dir   = 1'b1;
        kd       = 2'd0;
        is_space = (k == 8'h2C);
        case (k)
            8'h16:   kd = 2'd0;
            8'h1A:   kd = 2'd1;
            8'h04:   kd = 2'd2;
            8'h07:   kd = 2'd3;
            default: is_dir = 1'b0;
        endcase
        edge_hit     = is_space && !m_space_prev;
        m_space_prev = is_space;
        if (m_mode == M_ATTACK) begin
            m_atk_seen++;
            if (m_atk_seen == ATTACK_FRAMES) begin
                m_mode = M_IDLE;
                m_walk = 1'b0;
            end
        end else if (edge_hit) begin
            m_mode     = M_ATTACK;
            m_atk_seen = 0;
        end else if (is_dir) begin
            if (m_mode == M_WALK && kd == m_dir) begin
                m_steps++;
                if (m_steps % FRAME_DIV == 0) m_walk = ~m_walk;
            end else begin
                if (m_mode == M_IDLE) m_walk = 1'b0;
                m_mode  = M_WALK;
                m_dir   = kd;
                m_steps = 0;
            end
        end else begin
            m_mode = M_IDLE;
            m_walk = 1'b0;
        end
    endtask

    always @(posedge vga_clk) begin
        if (Reset) begin
            m_mode       = M_IDLE;
            m_dir        = 2'd0;
            m_walk       = 1'b0;
            m_steps      = 0;
            m_atk_seen   = 0;
            m_space_prev = 1'b0;
        end else if (bus.frame_tick) begin
            model_tick(bus.keycode);
        end
    end

    task automatic check_field(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, act, req);
        end
    endtask

    task automatic check_output();
        check_field("sprite_sel", int'(bus.sprite_sel), exp_sprite());
        check_field("dir",        int'(bus.dir),        int'(m_dir));
        check_field("walk_frame", int'(bus.walk_frame), int'(m_walk));
        check_field("attacking",  int'(bus.attacking),  int'(m_mode == M_ATTACK));
        check_field("moving",     int'(bus.moving),     int'(m_mode == M_WALK));
    endtask

    // Hand-computed expectations pin both the DUT and the model.
    task automatic check_lit(input string name, input int dut_v, input int model_v, input int want);
        check_field(name, dut_v, want);
        check_field({name, "_model"}, model_v, want);
    endtask

    always @(negedge vga_clk) begin
        if (check_en) check_output();
    end

    task automatic apply_stimulus(input logic tick, input logic [7:0] key, input logic rst);
        bus.frame_tick = tick;
        bus.keycode    = key;
        Reset          = rst;
        @(negedge vga_clk);
        bus.frame_tick = 1'b0;
        Reset          = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int         atk_ticks;
        int         m_atk_ticks;
        logic [7:0] cur_key;

        Reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.keycode    = 8'h00;
        repeat (3) @(negedge vga_clk);
        Reset    = 1'b0;
        check_en = 1'b1;
        check_lit("reset_sprite", int'(bus.sprite_sel), exp_sprite(), 0);
        check_lit("reset_attacking", int'(bus.attacking), int'(m_mode == M_ATTACK), 0);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'h00, 1'b0);
            check_lit("nokey_sprite", int'(bus.sprite_sel), exp_sprite(), 0);
            check_lit("nokey_moving", int'(bus.moving), int'(m_mode == M_WALK), 0);
        end

        for (int i = 1; i <= 17; i++) begin
            apply_stimulus(1'b0, 8'h07, 1'b0);
            apply_stimulus(1'b1, 8'h07, 1'b0);
            if (i == 1) begin
                check_lit("walk_t1_moving", int'(bus.moving), int'(m_mode == M_WALK), 1);
                check_lit("walk_t1_dir", int'(bus.dir), int'(m_dir), 3);
                check_lit("walk_t1_sprite", int'(bus.sprite_sel), exp_sprite(), 6);
            end
            if (i == 9) begin
                check_lit("walk_t9_frame", int'(bus.walk_frame), int'(m_walk), 1);
                check_lit("walk_t9_sprite", int'(bus.sprite_sel), exp_sprite(), 7);
            end
            if (i == 17) check_lit("walk_t17_frame", int'(bus.walk_frame), int'(m_walk), 0);
        end
        apply_stimulus(1'b1, 8'h00, 1'b0);
        check_lit("release_sprite", int'(bus.sprite_sel), exp_sprite(), 6);
        check_lit("release_moving", int'(bus.moving), int'(m_mode == M_WALK), 0);

        apply_stimulus(1'b0, 8'h07, 1'b0);
        apply_stimulus(1'b0, 8'h2C, 1'b0);
        apply_stimulus(1'b0, 8'h1A, 1'b0);
        apply_stimulus(1'b0, 8'h04, 1'b0);
        check_lit("notick_sprite", int'(bus.sprite_sel), exp_sprite(), 6);
        apply_stimulus(1'b1, 8'h1A, 1'b0);
        check_lit("up_dir", int'(bus.dir), int'(m_dir), 1);
        check_lit("up_sprite", int'(bus.sprite_sel), exp_sprite(), 2);

        apply_stimulus(1'b1, 8'h04, 1'b0);
        check_lit("left_sprite", int'(bus.sprite_sel), exp_sprite(), 4);
        apply_stimulus(1'b1, 8'h2C, 1'b0);
        check_lit("atk_enter_sprite", int'(bus.sprite_sel), exp_sprite(), 10);
        for (int i = 1; i < ATTACK_FRAMES; i++) begin
            apply_stimulus(1'b1, 8'h16, 1'b0);
            check_lit("atk_hold_attacking", int'(bus.attacking), int'(m_mode == M_ATTACK), 1);
            check_lit("atk_hold_sprite", int'(bus.sprite_sel), exp_sprite(), 10);
        end
        apply_stimulus(1'b1, 8'h16, 1'b0);
        check_lit("atk_end_sprite", int'(bus.sprite_sel), exp_sprite(), 4);
        check_lit("atk_end_attacking", int'(bus.attacking), int'(m_mode == M_ATTACK), 0);

        atk_ticks   = 0;
        m_atk_ticks = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'b1, 8'h2C, 1'b0);
            if (bus.attacking) atk_ticks++;
            if (m_mode == M_ATTACK) m_atk_ticks++;
        end
        check_lit("held_space_ticks", atk_ticks, m_atk_ticks, ATTACK_FRAMES);
        check_lit("held_space_after", int'(bus.attacking), int'(m_mode == M_ATTACK), 0);
        apply_stimulus(1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h2C, 1'b0);
        check_lit("repress_attacking", int'(bus.attacking), int'(m_mode == M_ATTACK), 1);

        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h2C, 1'b1);
        check_lit("rst_atk_sprite", int'(bus.sprite_sel), exp_sprite(), 0);
        check_lit("rst_atk_attacking", int'(bus.attacking), int'(m_mode == M_ATTACK), 0);
        check_lit("rst_atk_moving", int'(bus.moving), int'(m_mode == M_WALK), 0);

        cur_key = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 7))
                    0:       cur_key = 8'h00;
                    1:       cur_key = 8'h16;
                    2:       cur_key = 8'h1A;
                    3:       cur_key = 8'h04;
                    4:       cur_key = 8'h07;
                    5:       cur_key = 8'h2C;
                    6:       cur_key = 8'($urandom_range(0, 255));
                    default: cur_key = 8'h2C;
                endcase
            end
            apply_stimulus($urandom_range(0, 2) == 0, cur_key, $urandom_range(0, 149) == 0);
        end

        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_anim_ctrl.md
# sprite_anim_ctrl

Animation sequencer for the player sprite. It samples the USB keycode once per video frame and tracks facing direction, walk-cycle frame and a timed attack. It then emits a registered sprite select that chooses which 32x32 sprite ROM/palette drawing unit feeds the VGA colour path. All state changes happen only on the upstream frame tick, so the selected sprite never changes mid-frame.

## Interface
- FRAME_DIV, 8: frame ticks per walk-frame toggle while walking; must be ≥1.
- ATTACK_FRAMES, 12: frame ticks the attack pose is held; must be ≥1.

- vga_clk  input  1  the single clock for the block; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame, generated at the start of vertical blank.
- keycode  input  8  current USB HID keycode; 0x00 means no key.
- sprite_sel  output  4  index into the sprite ROM mux.
- dir  output  2  facing direction: 0 = down, 1 = up, 2 = left, 3 = right.
- walk_frame  output  1  walk-cycle phase.
- attacking  output  1  high while in the ATTACK state.
- moving  output  1  high while in the WALK state.

## Operation
- Key decode, applied only when frame_tick = 1:
  - 0x16 (S) → down; 0x1A (W) → up; 0x04 (A) → left; 0x07 (D) → right.
  - 0x2C (space) → attack.
  - Any other value is treated as no key.
- atk_edge = attack key present on this tick AND atk_prev = 0.
- atk_prev is updated to "attack key present" on every tick.
- A held space bar therefore triggers exactly one attack.
- States are IDLE, WALK and ATTACK. Transitions are evaluated only on cycles where frame_tick = 1.
- IDLE:
  - atk_edge → ATTACK, load atk_cnt = ATTACK_FRAMES-1.
  - Else direction key → WALK, set dir to the key, div_cnt = 0, walk_frame = 0.
  - Else stay in IDLE.
- WALK:
  - atk_edge → ATTACK, load atk_cnt; dir is kept.
  - Else same direction key → div_cnt++. When div_cnt = FRAME_DIV-1: div_cnt = 0 and walk_frame toggles.
  - Else different direction key → update dir, div_cnt = 0, walk_frame is kept.
  - Else no key → IDLE, walk_frame = 0, div_cnt = 0.
- ATTACK:
  - Keys are ignored (non-interruptible); atk_prev is still updated.
  - atk_cnt = 0 → IDLE with walk_frame = 0. Else atk_cnt--.
- Priority: attack edge beats direction key.
- Output encoding:
  - sprite_sel = {0, dir, walk_frame} when not attacking.
  - sprite_sel = {1, 0, dir} when attacking.
  - Codes 8–11 are the attack poses; codes 12–15 are never produced.
- moving = (state == WALK); attacking = (state == ATTACK).
- Counter widths: div_cnt is $clog2(FRAME_DIV+1) bits; atk_cnt is $clog2(ATTACK_FRAMES+1) bits. Neither wraps below 0.

## Timing
- All outputs are registered and update in the cycle after the frame_tick cycle that caused the change.
- Outputs are stable between ticks regardless of keycode activity.
- Reset:
  - Applies the cycle after Reset is sampled high.
  - state = IDLE, dir = 0, walk_frame = 0, div_cnt = 0, atk_cnt = 0, atk_prev = 0.
  - sprite_sel = 0, attacking = 0, moving = 0.
- Reset and frame_tick in the same cycle: Reset wins and the tick is discarded.
- Reset mid-attack or mid-walk: returns to IDLE immediately; no pending attack survives.
- Attack entered on tick T: attacking = 1 from T+1 cycle, through ticks T+1 … T+ATTACK_FRAMES-1. The tick at T+ATTACK_FRAMES returns to IDLE, so the pose lasts exactly ATTACK_FRAMES frames.
- Walk toggle period is exactly FRAME_DIV ticks of the same held direction key. With FRAME_DIV = 1, walk_frame toggles on every tick after entering WALK.
- frame_tick wider than one cycle: each high cycle counts as a tick. Upstream guarantees single-cycle pulses.

## Test plan
- Reset, then 3 ticks with keycode 0x00 → sprite_sel = 0, dir = 0, moving = 0, attacking = 0 throughout.
- Hold 0x07 for 17 ticks (FRAME_DIV = 8):
  - After tick 1: moving = 1, dir = 3, sprite_sel = 6.
  - After tick 9: walk_frame = 1, sprite_sel = 7.
  - After tick 17: walk_frame = 0.
  - Release key, then one tick → IDLE, sprite_sel = 6, moving = 0.
- Change keycode between ticks without any frame_tick → all outputs unchanged. Then hold 0x1A and tick → dir = 1, sprite_sel = 2.
- While walking left, press 0x2C on a tick:
  - attacking = 1, sprite_sel = 10 for exactly 12 ticks.
  - A 0x16 key during this period is ignored.
  - On the 12th following tick → IDLE with sprite_sel = 4.
- Hold 0x2C continuously for 30 ticks → exactly one 12-tick attack, then IDLE with attacking = 0. Release for one tick, press again → a new attack.
- Assert Reset at the 5th tick of an attack, coincident with frame_tick → next cycle sprite_sel = 0, attacking = 0, state = IDLE.
